// File: rtl/des_3.sv
// des_3: iterative triple-DES (EDE), one shared round datapath, 48 rounds.
// Ports:
//   clk, reset (sync, active-high)
//   desIn[63:0], key1/key2/key3[55:0] (parity-stripped), decrypt, start
//   desOut[63:0] (registered result), done (one-cycle pulse)
//   busy (only when DES_3_BUSY_OUT_EN is defined)
module des_3 (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] desIn,
    input  logic [55:0] key1,
    input  logic [55:0] key2,
    input  logic [55:0] key3,
    input  logic        decrypt,
    input  logic        start,
    output logic [63:0] desOut,
`ifdef DES_3_BUSY_OUT_EN
    output logic        busy,
`endif
    output logic        done
);

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    // Each entry: 64 nibbles, index = row*16 + col, first nibble at MSB.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        for (int k = 0; k < 64; k++) y[63-k] = x[64-IP_T[k]];
        return y;
    endfunction

    // FP is the inverse of IP, so it is built from the same table.
    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] y;
        for (int k = 0; k < 64; k++) y[64-IP_T[k]] = x[63-k];
        return y;
    endfunction

    // PC1 positions refer to the 64-bit key with a parity bit after
    // every 7 key bits; position p maps to stripped bit p - p/8.
    function automatic logic [55:0] pc1(input logic [55:0] k);
        logic [55:0] y;
        for (int i = 0; i < 56; i++)
            y[55-i] = k[56-(PC1_T[i] - PC1_T[i] / 8)];
        return y;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = cd[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [27:0] rol(input logic [27:0] v, input logic two);
        return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    endfunction

    function automatic logic [27:0] ror(input logic [27:0] v, input logic two);
        return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] so;
        logic [31:0] y;
        logic [5:0]  six;
        int          pos;
        int          idx;
        // E: each 6-bit group j takes R bits 4j..4j+5, wrapping 0->32, 33->1.
        for (int j = 0; j < 8; j++) begin
            for (int m = 0; m < 6; m++) begin
                pos = 4 * j + m;
                if (pos == 0) pos = 32;
                if (pos == 33) pos = 1;
                e[47-6*j-m] = r[32-pos];
            end
        end
        e = e ^ k;
        for (int s = 0; s < 8; s++) begin
            six = e[47-6*s -: 6];
            idx = int'({six[5], six[0], six[4:1]});
            so[31-4*s -: 4] = SBOX[s][255-4*idx -: 4];
        end
        for (int j = 0; j < 32; j++) y[31-j] = so[32-P_T[j]];
        return y;
    endfunction

    logic [31:0] l_q, l_d, r_q, r_d, f_out;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [55:0] k1_q, k2_q, k3_q, stage_key, cd_base;
    logic [47:0] subkey;
    logic [63:0] out_q, ip_in;
    logic [5:0]  cnt_q;
    logic [1:0]  stage;
    logic [3:0]  rnd;
    logic        busy_q, dec_q, done_q, stage_dec, one_step;

    assign stage     = cnt_q[5:4];
    assign rnd       = cnt_q[3:0];
    // Middle stage runs the opposite direction of the outer two.
    assign stage_dec = dec_q ^ (stage == 2'd1);
    assign one_step  = (rnd == 4'd1) || (rnd == 4'd8) || (rnd == 4'd15);
    assign ip_in     = ip(desIn);

    always_comb begin
        stage_key = k2_q;
        unique case (stage)
            2'd0:    stage_key = dec_q ? k3_q : k1_q;
            2'd2:    stage_key = dec_q ? k1_q : k3_q;
            default: stage_key = k2_q;
        endcase
    end

    always_comb begin
        // A fresh stage restarts C/D from its own key.
        cd_base = (rnd == 4'd0) ? pc1(stage_key) : {c_q, d_q};
        if (!stage_dec) begin
            c_d = rol(cd_base[55:28], !(one_step || rnd == 4'd0));
            d_d = rol(cd_base[27:0], !(one_step || rnd == 4'd0));
        end else if (rnd == 4'd0) begin
            // C16/D16 equal C0/D0, so K16 needs no rotation.
            c_d = cd_base[55:28];
            d_d = cd_base[27:0];
        end else begin
            c_d = ror(cd_base[55:28], !one_step);
            d_d = ror(cd_base[27:0], !one_step);
        end
        subkey = pc2({c_d, d_d});
        f_out  = feistel(r_q, subkey);
        // Last round of a stage keeps R16||L16 ordering; next stage's
        // IP(FP(x)) cancels, so this feeds straight into its round 1.
        if (rnd == 4'd15) begin
            l_d = l_q ^ f_out;
            r_d = r_q;
        end else begin
            l_d = r_q;
            r_d = l_q ^ f_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= 6'd0;
            out_q  <= 64'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q) begin
                if (start) begin
                    busy_q <= 1'b1;
                    cnt_q  <= 6'd0;
                    l_q    <= ip_in[63:32];
                    r_q    <= ip_in[31:0];
                    k1_q   <= key1;
                    k2_q   <= key2;
                    k3_q   <= key3;
                    dec_q  <= decrypt;
                end
            end else begin
                l_q   <= l_d;
                r_q   <= r_d;
                c_q   <= c_d;
                d_q   <= d_d;
                cnt_q <= cnt_q + 6'd1;
                if (cnt_q == 6'd47) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    cnt_q  <= 6'd0;
                    out_q  <= fp({l_d, r_d});
                end
            end
        end
    end

    assign desOut = out_q;
    assign done   = done_q;
`ifdef DES_3_BUSY_OUT_EN
    assign busy   = busy_q;
`endif

endmodule

// File: tb/tb_des_3.sv
// tb_des_3: randomized scoreboard bench for des_3 with a textbook
// triple-DES reference model.
module tb_des_3;

    logic        clk = 1'b0;
    logic        reset, decrypt, start, done;
    logic [63:0] desIn, desOut;
    logic [55:0] key1, key2, key3;

    des_3 dut (
        .clk(clk), .reset(reset), .desIn(desIn),
        .key1(key1), .key2(key2), .key3(key3),
        .decrypt(decrypt), .start(start),
        .desOut(desOut), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int T_IP [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int T_FP [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
    localparam int T_E [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    localparam int T_P [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    localparam int T_PC1 [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int T_PC2 [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int T_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam logic [255:0] T_S [8] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

    function automatic logic [31:0] fref(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s, p;
        logic [5:0]  b;
        int          row, col;
        for (int j = 0; j < 48; j++) e[47-j] = r[32-T_E[j]];
        e = e ^ k;
        for (int i = 0; i < 8; i++) begin
            b = e[47-6*i -: 6];
            row = int'({b[5], b[0]});
            col = int'(b[4:1]);
            s[31-4*i -: 4] = T_S[i][255-4*(16*row+col) -: 4];
        end
        for (int j = 0; j < 32; j++) p[31-j] = s[32-T_P[j]];
        return p;
    endfunction

    // Single DES on a full 64-bit key (parity bits ignored by PC1).
    function automatic logic [63:0] des_ref(input logic [63:0] key,
                                            input logic [63:0] blk, input bit dec);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] ks [16];
        logic [63:0] x, y;
        logic [31:0] l, r, t;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-T_PC1[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int n = 0; n < T_SH[i]; n++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int j = 0; j < 48; j++) ks[i][47-j] = cd[56-T_PC2[j]];
        end
        for (int i = 0; i < 64; i++) x[63-i] = blk[64-T_IP[i]];
        l = x[63:32];
        r = x[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ fref(r, ks[dec ? 15 - i : i]);
            l = t;
        end
        x = {r, l};
        for (int i = 0; i < 64; i++) y[63-i] = x[64-T_FP[i]];
        return y;
    endfunction

    function automatic logic [63:0] tdes(input logic [63:0] k1, k2, k3,
                                         input logic [63:0] blk, input bit dec);
        if (!dec) return des_ref(k3, des_ref(k2, des_ref(k1, blk, 1'b0), 1'b1), 1'b0);
        return des_ref(k1, des_ref(k2, des_ref(k3, blk, 1'b1), 1'b0), 1'b1);
    endfunction

    function automatic logic [55:0] strip(input logic [63:0] k);
        logic [55:0] s;
        for (int b = 0; b < 8; b++) s[55-7*b -: 7] = k[63-8*b -: 7];
        return s;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    typedef struct packed {
        logic [63:0] out;
        int          c0;
    } exp_t;

    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    bit          checking = 1'b0;
    bit          done_prev = 1'b0;
    logic [63:0] exp_hold = 64'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic scramble();
        desIn   = rnd64();
        key1    = strip(rnd64());
        key2    = strip(rnd64());
        key3    = strip(rnd64());
        decrypt = ~decrypt;
    endtask

    task automatic set_in(input logic [63:0] k1, k2, k3, blk, input bit dec);
        key1    = strip(k1);
        key2    = strip(k2);
        key3    = strip(k3);
        desIn   = blk;
        decrypt = dec;
    endtask

    task automatic push(input logic [63:0] expv);
        exp_t e;
        e.out = expv;
        e.c0  = cyc;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [63:0] k1, k2, k3, blk, input bit dec,
                         input logic [63:0] expv);
        set_in(k1, k2, k3, blk, dec);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        push(expv);
        scramble();
    endtask

    always @(negedge clk) begin
        if (checking) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", {63'd0, done}, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("desOut", desOut, e.out);
                    chk("latency", 64'(cyc - e.c0), 64'd48);
                    exp_hold = e.out;
                end
                chk("done_pulse", {63'd0, done_prev}, 64'd0);
            end else begin
                chk("hold", desOut, exp_hold);
            end
            done_prev = done;
        end
    end

    localparam logic [63:0] KX = 64'h133457799BBCDFF1;

    initial begin
        logic [63:0] ka, kb, kc, p, c;
        reset = 1'b1;
        start = 1'b0;
        decrypt = 1'b0;
        desIn = 64'd0;
        key1 = 56'd0;
        key2 = 56'd0;
        key3 = 56'd0;
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_desOut", desOut, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        exp_hold = 64'd0;
        checking = 1'b1;
        @(posedge clk);
        #2;

        issue(0, 0, 0, 64'h95F8A5E5DD31D900, 1'b0, 64'h8000000000000000);
        tick(48);
        issue(0, 0, 0, 64'h8000000000000000, 1'b1, 64'h95F8A5E5DD31D900);
        tick(48);
        issue(KX, KX, KX, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405);
        tick(48);
        issue(KX, KX, KX, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF);
        tick(48);

        for (int i = 0; i < 4; i++) begin
            ka = rnd64();
            kb = rnd64();
            kc = rnd64();
            p  = rnd64();
            c  = tdes(ka, kb, kc, p, 1'b0);
            issue(ka, kb, kc, p, 1'b0, c);
            tick(48);
            issue(ka, kb, kc, c, 1'b1, p);
            tick(48);
        end

        for (int i = 0; i < 2; i++) begin
            ka = rnd64();
            kb = rnd64();
            p  = rnd64();
            issue(ka, ka, kb, p, 1'b0, des_ref(kb, p, 1'b0));
            tick(48);
            issue(ka, ka, kb, p, 1'b1, des_ref(kb, p, 1'b1));
            tick(48);
        end

        ka = rnd64();
        kb = rnd64();
        kc = rnd64();
        p  = rnd64();
        issue(ka, kb, kc, p, 1'b1, tdes(ka, kb, kc, p, 1'b1));
        tick(9);
        scramble();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(38);

        p = rnd64();
        issue(ka, kb, kc, p, 1'b0, tdes(ka, kb, kc, p, 1'b0));
        tick(47);
        c = rnd64();
        set_in(kc, ka, kb, c, 1'b0);
        start = 1'b1;
        tick(2);
        start = 1'b0;
        push(tdes(kc, ka, kb, c, 1'b0));
        scramble();
        tick(48);

        p = rnd64();
        issue(ka, kb, kc, p, 1'b0, tdes(ka, kb, kc, p, 1'b0));
        tick(19);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        sb.delete();
        exp_hold = 64'd0;
        tick(40);

        p = rnd64();
        issue(kb, kc, ka, p, 1'b1, tdes(kb, kc, ka, p, 1'b1));
        tick(48);

        for (int i = 0; i < 10 && sb.size() != 0; i++) tick(1);
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
